// File: rtl/uart_rx_core_if.sv
// ---------------------------------------------------------------------------
// uart_rx_core_if
// Byte stream leaving the UART receive core.
//   m_data  : head byte of the output FIFO (LSB = first received data bit)
//   m_valid : FIFO not empty; m_data is meaningful only while this is high
//   m_ready : consumer accepts the head byte on this cycle
// master = the receive core (producer), slave = the command decoder.
// ---------------------------------------------------------------------------
interface uart_rx_core_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] m_data;
   logic                 m_valid;
   logic                 m_ready;

   modport master (output m_data, output m_valid, input m_ready);
   modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/uart_rx_core.sv
// ---------------------------------------------------------------------------
// uart_rx_core
// UART receiver with 16x oversampling, 3-sample majority vote per bit,
// optional even/odd parity, error pulses and a first-word-fall-through
// output FIFO.
// Ports:
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   rx         : serial line (idles high, asynchronous to clk)
//   m_if       : byte stream out (m_data / m_valid / m_ready)
//   frame_err  : 1-cycle pulse, stop bit sampled 0
//   parity_err : 1-cycle pulse, parity mismatch (good stop bit)
//   overrun    : 1-cycle pulse, good byte dropped because the FIFO is full
// ---------------------------------------------------------------------------
module uart_rx_core #(
   parameter int CLK_HZ     = 50_000_000,
   parameter int BAUD       = 115200,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int FIFO_DEPTH = 4
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     rx,
   uart_rx_core_if.master m_if,
   output logic     frame_err,
   output logic     parity_err,
   output logic     overrun
);
   // rounded divide for the oversample rate
   localparam int OS_DIV = (CLK_HZ + BAUD * 8) / (BAUD * 16);
   localparam int TICK_W = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
   localparam int AW     = $clog2(FIFO_DEPTH);

   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OS_DIV - 1);
   localparam logic [2:0]        BIT_LAST  = 3'(DATA_BITS - 1);
   localparam logic              ODD_PAR   = (PARITY == 2);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;
   localparam logic [2:0] S_BREAK  = 3'd5;

   logic                 r_rx_meta, r_rxs, r_rxs_prev;
   logic [TICK_W-1:0]    r_tick_cnt;
   logic [3:0]           r_sub;
   logic                 r_s7, r_s8;
   logic [2:0]           r_state;
   logic [2:0]           r_bit_cnt;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_par_bad;
   logic                 r_push;
   logic [DATA_BITS-1:0] r_push_data;

   logic                 w_tick, w_fall, w_decide, w_bit_end, w_maj;

   assign w_tick    = (r_tick_cnt == TICK_LAST);
   assign w_fall    = (r_state == S_IDLE) && r_rxs_prev && !r_rxs;
   assign w_decide  = w_tick && (r_sub == 4'd9);
   assign w_bit_end = w_tick && (r_sub == 4'd15);
   // third vote is the live sample taken at the sub-tick 9 decision
   assign w_maj     = (r_s7 & r_s8) | (r_s7 & r_rxs) | (r_s8 & r_rxs);

   // two-flop synchroniser plus previous value for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_meta  <= 1'b1;
         r_rxs      <= 1'b1;
         r_rxs_prev <= 1'b1;
      end else begin
         r_rx_meta  <= rx;
         r_rxs      <= r_rx_meta;
         r_rxs_prev <= r_rxs;
      end
   end

   // oversample tick and sub-bit position; both realign to the start edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tick_cnt <= '0;
         r_sub      <= '0;
         r_s7       <= 1'b1;
         r_s8       <= 1'b1;
      end else begin
         if (w_fall || w_tick) r_tick_cnt <= '0;
         else                  r_tick_cnt <= r_tick_cnt + 1'b1;

         if (r_state == S_IDLE) r_sub <= '0;
         else if (w_tick)       r_sub <= r_sub + 4'd1;

         if (w_tick && r_sub == 4'd7) r_s7 <= r_rxs;
         if (w_tick && r_sub == 4'd8) r_s8 <= r_rxs;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_bit_cnt   <= '0;
         r_shift     <= '0;
         r_par_bad   <= 1'b0;
         r_push      <= 1'b0;
         r_push_data <= '0;
         frame_err   <= 1'b0;
         parity_err  <= 1'b0;
      end else begin
         r_push     <= 1'b0;
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_fall) r_state <= S_START;
            end
            S_START: begin
               r_par_bad <= 1'b0;
               if (w_decide && w_maj) begin
                  r_state <= S_IDLE;          // glitch, not a start bit
               end else if (w_bit_end) begin
                  r_state   <= S_DATA;
                  r_bit_cnt <= '0;
               end
            end
            S_DATA: begin
               if (w_decide) r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
               if (w_bit_end) begin
                  if (r_bit_cnt == BIT_LAST)
                     r_state <= (PARITY != 0) ? S_PARITY : S_STOP;
                  else
                     r_bit_cnt <= r_bit_cnt + 3'd1;
               end
            end
            S_PARITY: begin
               if (w_decide) r_par_bad <= w_maj ^ (^r_shift) ^ ODD_PAR;
               if (w_bit_end) r_state <= S_STOP;
            end
            S_STOP: begin
               // leave at the centre of the stop bit so a back-to-back
               // start edge is still caught in IDLE
               if (w_decide) begin
                  if (!w_maj) begin
                     frame_err <= 1'b1;
                     r_state   <= S_BREAK;
                  end else if (r_par_bad) begin
                     parity_err <= 1'b1;
                     r_state    <= S_IDLE;
                  end else begin
                     r_push      <= 1'b1;
                     r_push_data <= r_shift;
                     r_state     <= S_IDLE;
                  end
               end
            end
            S_BREAK: begin
               if (r_rxs) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // output FIFO, first-word fall-through
   logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
   logic [AW:0]          r_wr_ptr, r_rd_ptr;
   logic                 w_empty, w_full, w_pop, w_wr;

   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_pop   = !w_empty && m_if.m_ready;
   // a pop frees the head slot this cycle, so a full FIFO can still accept
   assign w_wr    = r_push && (!w_full || w_pop);
   assign overrun = r_push && w_full && !w_pop;

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= r_push_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   assign m_if.m_valid = !w_empty;
   assign m_if.m_data  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
endmodule
